test_pattern_checker: RTL and testbench

- Receive-side counterpart of the 4-bit test pattern generator: samples the generated pattern stream and checks it against the expected sequence.
- Acquires lock, flags mismatches, and keeps a saturating error count.
- Sits at the far end of a link/datapath under test and supports the same static (mode=0) and dynamic (mode=1) patterns as the generator.

---
 rtl/test_pattern_checker_pkg.sv | 20 ++
 rtl/test_pattern_checker_sat_counter.sv | 28 ++
 rtl/test_pattern_checker.sv | 130 +++++++++++++
 tb/tb_test_pattern_checker.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/test_pattern_checker_pkg.sv
// Definitions shared by the 4-bit test pattern generator and checker, so the
// two ends of the link can never disagree on the pattern or the LFSR taps.
package test_pattern_checker_pkg;

  localparam logic MODE_STATIC  = 1'b0;
  localparam logic MODE_DYNAMIC = 1'b1;

  localparam logic [3:0] STATIC_PATTERN_DEFAULT = 4'b1010;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  // Fibonacci LFSR, taps on bits 3 and 2: period 15; the all-zero word is a dead state.
  function automatic logic [3:0] lfsr_next(input logic [3:0] p);
    return {p[2:0], p[3] ^ p[2]};
  endfunction

endpackage

// File: rtl/test_pattern_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples values from before the edge regardless of block order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/test_pattern_checker.sv
// Receive-side pattern checker: acquires lock on a static or LFSR stream,
// pulses error on mismatches while locked and keeps a saturating error count.
module test_pattern_checker
  import test_pattern_checker_pkg::*;
#(
  parameter logic [3:0] STATIC_PATTERN = STATIC_PATTERN_DEFAULT,
  parameter int         LOCK_COUNT     = 4,
  parameter int         LOSS_COUNT     = 4,
  parameter int         ERR_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             valid,
  input  logic [3:0]       pattern,
  input  logic             clear_count,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] err_count
);

  chk_state_e state_q, state_d;
  logic [3:0] good_q, good_d;
  logic [3:0] bad_q, bad_d;
  logic [3:0] ref_q, ref_d;
  logic       seeded_q, seeded_d;
  logic       mode_q;
  logic       error_q, error_d;
  logic       err_inc;
  logic       dyn;
  logic [3:0] expected;
  logic       match;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SEARCH;
      good_q   <= '0;
      bad_q    <= '0;
      ref_q    <= '0;
      seeded_q <= 1'b0;
      mode_q   <= MODE_STATIC;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      ref_q    <= ref_d;
      seeded_q <= seeded_d;
      mode_q   <= mode;
      error_q  <= error_d;
    end
  end

  // In SEARCH, ref_q tracks next(last valid sample), so one expected-value
  // path serves both states in dynamic mode.
  assign dyn      = (mode == MODE_DYNAMIC);
  assign expected = dyn ? ref_q : STATIC_PATTERN;
  assign match    = (pattern == expected) && !(dyn && (pattern == 4'b0000));

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    bad_d    = bad_q;
    ref_d    = ref_q;
    seeded_d = seeded_q;
    error_d  = 1'b0;
    err_inc  = 1'b0;

    if (mode != mode_q) begin
      state_d  = SEARCH;
      good_d   = '0;
      bad_d    = '0;
      seeded_d = 1'b0;
    end else if (valid) begin
      unique case (state_q)
        SEARCH: begin
          ref_d = lfsr_next(pattern);
          if (dyn && !seeded_q) begin
            seeded_d = 1'b1;
          end else if (match) begin
            if (good_q == 4'(LOCK_COUNT - 1)) begin
              state_d = LOCKED;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              good_d = good_q + 4'd1;
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          // The reference free-runs so one bad word does not poison the next compare.
          ref_d = lfsr_next(ref_q);
          if (match) begin
            bad_d = '0;
          end else begin
            error_d = 1'b1;
            err_inc = 1'b1;
            if (bad_q == 4'(LOSS_COUNT - 1)) begin
              state_d  = SEARCH;
              good_d   = '0;
              bad_d    = '0;
              seeded_d = 1'b0;
            end else begin
              bad_d = bad_q + 4'd1;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_count (
    .clk_i  (clk),
    .rst_i  (reset),
    .inc_i  (err_inc),
    .clr_i  (clear_count),
    .count_o(err_count)
  );

  assign locked = (state_q == LOCKED);
  assign error  = error_q;

endmodule

// File: tb/tb_test_pattern_checker.sv
// Directed bench for test_pattern_checker: a default instance plus a 2-bit
// error-counter instance sharing the same stimulus for the saturation case.
module tb_test_pattern_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic       clear_count = 1'b0;

  logic       locked, error;
  logic [7:0] err_count;
  logic       locked_s, error_s;
  logic [1:0] err_count_s;

  int total = 0;
  int bad = 0;
  int idx = 0;
  logic [3:0] seq [15];

  always #5 clk = ~clk;

  test_pattern_checker dut (
    .clk(clk), .reset(reset), .mode(mode), .valid(valid), .pattern(pattern),
    .clear_count(clear_count), .locked(locked), .error(error), .err_count(err_count)
  );

  test_pattern_checker #(.ERR_W(2)) dut_sat (
    .clk(clk), .reset(reset), .mode(mode), .valid(valid), .pattern(pattern),
    .clear_count(clear_count), .locked(locked_s), .error(error_s), .err_count(err_count_s)
  );

  task automatic drive(input logic v, input logic [3:0] p, input logic c);
    @(negedge clk);
    valid = v;
    pattern = p;
    clear_count = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", error); end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_static_lock();
    mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'b1010, 1'b0);
      total++; if (locked !== (i >= 3)) begin bad++; $display("FAIL static_lock[%0d]: got %b want %b", i, locked, (i >= 3)); end
      total++; if (error !== 1'b0) begin bad++; $display("FAIL static_error[%0d]: got %b want 0", i, error); end
    end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL static_err_count: got %0d want 0", err_count); end
  endtask

  task automatic test_dynamic_lock();
    mode = 1'b1;
    drive(1'b0, 4'b0000, 1'b0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL mode_change_unlock: got %b want 0", locked); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, seq[i], 1'b0);
      total++; if (locked !== (i == 4)) begin bad++; $display("FAIL dyn_lock[%0d]: got %b want %b", i, locked, (i == 4)); end
      total++; if (error !== 1'b0) begin bad++; $display("FAIL dyn_error[%0d]: got %b want 0", i, error); end
    end
    idx = 5;
  endtask

  task automatic test_single_error();
    drive(1'b1, 4'b0111, 1'b0);
    total++; if (error !== 1'b1) begin bad++; $display("FAIL single_err_pulse: got %b want 1", error); end
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL single_err_count: got %0d want 1", err_count); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL single_err_locked: got %b want 1", locked); end
    for (int k = 6; k < 9; k++) begin
      drive(1'b1, seq[k], 1'b0);
      total++; if (error !== 1'b0) begin bad++; $display("FAIL single_err_after[%0d]: got %b want 0", k, error); end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL single_err_lock_hold[%0d]: got %b want 1", k, locked); end
      total++; if (err_count !== 8'd1) begin bad++; $display("FAIL single_err_count_hold[%0d]: got %0d want 1", k, err_count); end
    end
  endtask

  task automatic test_loss_of_lock();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'b0000, 1'b0);
      total++; if (error !== 1'b1) begin bad++; $display("FAIL loss_err[%0d]: got %b want 1", i, error); end
      total++; if (err_count !== 8'(2 + i)) begin bad++; $display("FAIL loss_count[%0d]: got %0d want %0d", i, err_count, 2 + i); end
      total++; if (locked !== (i < 3)) begin bad++; $display("FAIL loss_locked[%0d]: got %b want %b", i, locked, (i < 3)); end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, seq[i], 1'b0);
      total++; if (locked !== (i == 4)) begin bad++; $display("FAIL relock[%0d]: got %b want %b", i, locked, (i == 4)); end
      total++; if (error !== 1'b0) begin bad++; $display("FAIL relock_err[%0d]: got %b want 0", i, error); end
    end
    total++; if (err_count !== 8'd5) begin bad++; $display("FAIL relock_count: got %0d want 5", err_count); end
  endtask

  task automatic test_saturation_clear();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 4'b0000, 1'b0);
    total++; if (err_count_s !== 2'd0) begin bad++; $display("FAIL sat_reset: got %0d want 0", err_count_s); end
    for (int i = 0; i < 5; i++) drive(1'b1, seq[i], 1'b0);
    total++; if (locked_s !== 1'b1) begin bad++; $display("FAIL sat_locked: got %b want 1", locked_s); end
    idx = 5;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0000, 1'b0);
      total++; if (error_s !== 1'b1) begin bad++; $display("FAIL sat_err[%0d]: got %b want 1", i, error_s); end
      total++; if (err_count_s !== ((i < 3) ? 2'(i + 1) : 2'd3)) begin bad++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, err_count_s, (i < 3) ? i + 1 : 3); end
      drive(1'b1, seq[(idx + 1) % 15], 1'b0);
      idx += 2;
      total++; if (locked_s !== 1'b1 || error_s !== 1'b0) begin bad++; $display("FAIL sat_match[%0d]: got locked=%b error=%b want 1/0", i, locked_s, error_s); end
    end
    drive(1'b1, 4'b0000, 1'b1);
    total++; if (err_count_s !== 2'd0) begin bad++; $display("FAIL clear_wins_sat: got %0d want 0", err_count_s); end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL clear_wins: got %0d want 0", err_count); end
    total++; if (error_s !== 1'b1) begin bad++; $display("FAIL clear_err_pulse: got %b want 1", error_s); end
    drive(1'b1, seq[(idx + 1) % 15], 1'b0);
    idx += 2;
    total++; if (locked !== 1'b1 || err_count !== 8'd0) begin bad++; $display("FAIL post_clear: got locked=%b count=%0d want 1/0", locked, err_count); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 4'b0000, 1'b0);
    valid = 1'b0;
    total++; if (error !== 1'b1 || err_count !== 8'd1) begin bad++; $display("FAIL pre_reset: got error=%b count=%0d want 1/1", error, err_count); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL async_rst_locked: got %b want 0", locked); end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL async_rst_count: got %0d want 0", err_count); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL async_rst_error: got %b want 0", error); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mode_change();
    drive(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, seq[i], 1'b0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL mc_locked: got %b want 1", locked); end
    drive(1'b1, 4'b0000, 1'b0);
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL mc_pre_count: got %0d want 1", err_count); end
    mode = 1'b0;
    drive(1'b0, 4'b0000, 1'b0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL mc_unlock: got %b want 0", locked); end
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL mc_count_held: got %0d want 1", err_count); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL mc_error: got %b want 0", error); end
    drive(1'b1, 4'b0101, 1'b0);
    total++; if (error !== 1'b0 || err_count !== 8'd1) begin bad++; $display("FAIL search_no_err: got error=%b count=%0d want 0/1", error, err_count); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'b1010, 1'b0);
      total++; if (locked !== (i == 3)) begin bad++; $display("FAIL mc_static_lock[%0d]: got %b want %b", i, locked, (i == 3)); end
    end
  endtask

  initial begin
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
            4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    test_reset();
    test_static_lock();
    test_dynamic_lock();
    test_single_error();
    test_loss_of_lock();
    test_saturation_clear();
    test_async_reset();
    test_mode_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
